// File: rtl/servo_pwm_bank.sv
// Multi-channel hobby-servo PWM bank with a shared frame timebase.
// Define SERVO_SLEW_EN to step-limit each joint by SLEW_LSB per frame.
module servo_pwm_bank #(
  parameter int N_CH       = 5,
  parameter int CLK_HZ     = 50_000_000,
  parameter int PERIOD_US  = 20000,
  parameter int MIN_US     = 1000,
  parameter int MAX_US     = 2000,
  parameter int US_PER_LSB = 4,
  parameter int HOME_POS   = 128,
  parameter int SLEW_LSB   = 8
) (
  input  logic              CLOCK_50,
  input  logic              rst,
  input  logic [8*N_CH-1:0] tgt_pos,
  input  logic              tgt_load,
  input  logic [N_CH-1:0]   ch_en,
  output logic [N_CH-1:0]   pwm,
  output logic              frame_start,
  output logic              busy
);

  localparam int DIV = CLK_HZ / 1_000_000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
  localparam logic [15:0]   US_MAX  = 16'(PERIOD_US - 1);
  localparam logic [7:0]    HOME    = 8'(HOME_POS);

  function automatic logic [15:0] width_of(input logic [7:0] p);
    logic [15:0] w;
    w = 16'(MIN_US) + 16'(p) * 16'(US_PER_LSB);
    return (w > 16'(MAX_US)) ? 16'(MAX_US) : w;
  endfunction

  logic [PW-1:0] pre;
  logic [15:0]   us_cnt;
  logic          tick;
  logic          boundary;

  logic [7:0]  cur_pos  [N_CH];
  logic [7:0]  tgt      [N_CH];
  logic [7:0]  nxt_pos  [N_CH];
  logic [15:0] width_us [N_CH];

  assign tick     = (pre == PRE_MAX);
  assign boundary = tick && (us_cnt == US_MAX);

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      pre         <= '0;
      us_cnt      <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= boundary;
      pre         <= tick ? '0 : pre + 1'b1;
      if (tick)
        us_cnt <= (us_cnt == US_MAX) ? '0 : us_cnt + 16'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      nxt_pos[i] = tgt[i];
`ifdef SERVO_SLEW_EN
      if (tgt[i] > cur_pos[i] && (tgt[i] - cur_pos[i]) > 8'(SLEW_LSB))
        nxt_pos[i] = cur_pos[i] + 8'(SLEW_LSB);
      else if (cur_pos[i] > tgt[i] && (cur_pos[i] - tgt[i]) > 8'(SLEW_LSB))
        nxt_pos[i] = cur_pos[i] - 8'(SLEW_LSB);
`endif
    end
  end

  // A load coincident with a boundary lands in tgt after that boundary
  // has already sampled the old value.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        tgt[i]      <= HOME;
        cur_pos[i]  <= HOME;
        width_us[i] <= width_of(HOME);
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (tgt_load)
          tgt[i] <= tgt_pos[8*i +: 8];
        if (boundary) begin
          cur_pos[i]  <= nxt_pos[i];
          width_us[i] <= width_of(nxt_pos[i]);
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      pwm <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++)
        pwm[i] <= ch_en[i] && (us_cnt < width_us[i]);
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < N_CH; i++)
      busy = busy | (cur_pos[i] != tgt[i]);
  end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Directed bench for servo_pwm_bank on a scaled-down timebase
// (2 cycles/us, 800 us frame, 100..600 us pulses, 2 us/LSB).
module tb_servo_pwm_bank;

  localparam int FRAME = 1600;

`ifdef SERVO_SLEW_EN
  localparam bit SLEW = 1'b1;
`else
  localparam bit SLEW = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [39:0] tgt_pos;
  logic        tgt_load;
  logic [4:0]  ch_en;
  logic [4:0]  pwm;
  logic        frame_start;
  logic        busy;

  servo_pwm_bank #(
    .N_CH(5), .CLK_HZ(2_000_000), .PERIOD_US(800),
    .MIN_US(100), .MAX_US(600), .US_PER_LSB(2),
    .HOME_POS(128), .SLEW_LSB(8)
  ) dut (
    .CLOCK_50(clk), .rst(rst), .tgt_pos(tgt_pos),
    .tgt_load(tgt_load), .ch_en(ch_en), .pwm(pwm),
    .frame_start(frame_start), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [39:0] tgt;
    logic [4:0]  en;
    int          e0, e1, e2, e3, e4;
  } vec_t;

  vec_t vec [4];
  int   n_chk = 0;
  int   n_fail = 0;
  int   wid [5];
  bit   fs_busy;

  function automatic logic [39:0] pk(input int a, b, c, d, e);
    return {8'(e), 8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic vec_t mk(input logic [39:0] t, input logic [4:0] en,
                              input int e0, e1, e2, e3, e4);
    vec_t v;
    v.tgt = t; v.en = en;
    v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3; v.e4 = e4;
    return v;
  endfunction

  function automatic int cyc(input int p);
    int w;
    w = 100 + 2 * p;
    if (w > 600) w = 600;
    return 2 * w;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_fs(output int c);
    c = 0;
    do begin
      @(negedge clk);
      tgt_load = 1'b0;
      c++;
    end while (!frame_start && c < FRAME + 8);
    if (!frame_start) begin
      n_chk++;
      n_fail++;
      $display("FAIL frame_start_timeout: got 0 expected 1");
    end
  endtask

  // Counts high cycles per channel over one frame; optional load at cycle k.
  task automatic measure(input int load_at, input logic [39:0] val);
    int c;
    wait_fs(c);
    fs_busy = busy;
    for (int ch = 0; ch < 5; ch++) wid[ch] = 0;
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) @(negedge clk);
      tgt_load = 1'b0;
      if (k == load_at) begin
        tgt_pos  = val;
        tgt_load = 1'b1;
      end
      for (int ch = 0; ch < 5; ch++)
        if (pwm[ch]) wid[ch]++;
    end
  endtask

  task automatic chk_w(input string nm, input int e0, e1, e2, e3, e4);
    chk({nm, "_ch0"}, wid[0], e0);
    chk({nm, "_ch1"}, wid[1], e1);
    chk({nm, "_ch2"}, wid[2], e2);
    chk({nm, "_ch3"}, wid[3], e3);
    chk({nm, "_ch4"}, wid[4], e4);
  endtask

  initial begin
    int c;
    int p0, p1, p2;
    vec[0] = mk(pk(128, 128, 128, 128, 128), 5'h1F, 712, 712, 712, 712, 712);
    vec[1] = mk(pk(130, 124, 136, 120, 128), 5'h1F, 720, 696, 744, 680, 712);
    vec[2] = mk(pk(135, 120, 136, 127, 129), 5'h1B, 740, 680, 0, 708, 716);
    vec[3] = mk(pk(135, 120, 136, 127, 129), 5'h1F, 740, 680, 744, 708, 716);

    rst = 1'b1;
    ch_en = 5'h1F;
    tgt_pos = pk(128, 128, 128, 128, 128);
    tgt_load = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_pwm", int'(pwm), 0);
    chk("reset_fs", int'(frame_start), 0);
    chk("reset_busy", int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("first_pulse", int'(pwm), 5'h1F);
    wait_fs(c);
    wait_fs(c);
    chk("frame_period", c, FRAME);

    for (int i = 0; i < 4; i++) begin
      ch_en = vec[i].en;
      measure(100, vec[i].tgt);
      measure(-1, '0);
      chk_w($sformatf("vec%0d", i),
            vec[i].e0, vec[i].e1, vec[i].e2, vec[i].e3, vec[i].e4);
      chk($sformatf("vec%0d_busy", i), int'(fs_busy), 0);
    end

    measure(100, pk(131, 126, 132, 131, 131));
    chk_w("midpulse_hold", 740, 680, 744, 708, 716);
    measure(FRAME - 1, pk(133, 133, 133, 133, 133));
    chk_w("midpulse_apply", 724, 704, 728, 724, 724);
    chk("midpulse_busy", int'(fs_busy), 0);
    measure(-1, '0);
    chk_w("coinc_hold", 724, 704, 728, 724, 724);
    chk("coinc_busy", int'(fs_busy), 1);
    measure(-1, '0);
    chk_w("coinc_apply", 732, 732, 732, 732, 732);
    chk("coinc_busy_done", int'(fs_busy), 0);

    wait_fs(c);
    repeat (50) @(negedge clk);
    chk("pre_rst_pwm", int'(pwm), 5'h1F);
    rst = 1'b1;
    #1;
    chk("rst_drop_pwm", int'(pwm), 0);
    chk("rst_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    measure(100, pk(0, 255, 200, 128, 128));
    chk_w("post_rst", 712, 712, 712, 712, 712);
    chk("post_rst_busy", int'(fs_busy), 0);

    for (int k = 1; k <= 16; k++) begin
      ch_en = (k >= 3 && k <= 5) ? 5'h1B : 5'h1F;
      measure(-1, '0);
      if (SLEW) begin
        p0 = (8 * k >= 128) ? 0 : 128 - 8 * k;
        p1 = (128 + 8 * k > 255) ? 255 : 128 + 8 * k;
        p2 = (128 + 8 * k > 200) ? 200 : 128 + 8 * k;
      end else begin
        p0 = 0; p1 = 255; p2 = 200;
      end
      chk_w($sformatf("ramp%0d", k), cyc(p0), cyc(p1),
            (k >= 3 && k <= 5) ? 0 : cyc(p2), 712, 712);
      chk($sformatf("ramp%0d_busy", k), int'(fs_busy),
          (SLEW && k < 16) ? 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
